// File: rtl/spi_master_core.sv
// rtl/spi_master_core.sv - Mode-0 SPI master bit engine fed by TX/RX FIFOs
// Byte loop: LOAD pops the TX head, SHIFT clocks bits MSB-first, STORE pushes the RX byte.
module spi_master_core #(
   parameter int DATA = 8,
   parameter int DIV  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [15:0]     len,
   input  logic            op,
   input  logic            work,
   output logic            busy,
   input  logic [DATA-1:0] tx_data,
   output logic            tx_rd,
   input  logic            tx_empty,
   output logic [DATA-1:0] rx_data,
   output logic            rx_wr,
   input  logic            rx_full,
   output logic            sclk,
   output logic            mosi,
   input  logic            miso,
   output logic            cs_n
);

   localparam int            BW        = $clog2(DATA + 1);
   localparam logic [7:0]    DIV_LAST  = 8'(DIV - 1);
   localparam logic [15:0]   DATA_BITS = 16'(DATA);
   localparam logic [BW-1:0] DATA_BW   = BW'(DATA);
   localparam logic [BW-1:0] ONE_BW    = BW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_STORE,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [15:0]     bits_left;
   logic [BW-1:0]   byte_bits;
   logic [7:0]      div_cnt;
   logic            op_q;
   logic [DATA-1:0] tx_sr;
   logic [DATA-1:0] rx_sr;
   logic            sclk_q;
   logic            cs_n_q;
   logic            busy_q;

   logic            div_end;
   logic            start;
   logic            rise;
   logic            fall;

   assign div_end = (div_cnt == DIV_LAST);

   assign busy    = busy_q;
   assign sclk    = sclk_q;
   assign cs_n    = cs_n_q;
   assign mosi    = tx_sr[DATA-1];
   assign rx_data = rx_sr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      rise      = 1'b0;
      fall      = 1'b0;
      tx_rd     = 1'b0;
      rx_wr     = 1'b0;
      case (state)
         S_IDLE: begin
            if (work && (len != 16'd0)) begin
               start     = 1'b1;
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            // An empty FIFO is an underrun: zeros go out and nothing stalls.
            tx_rd     = !tx_empty;
            state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            if (div_end) begin
               if (!sclk_q) begin
                  rise = 1'b1;
               end else begin
                  fall = 1'b1;
                  if (byte_bits == ONE_BW) begin
                     state_nxt = S_STORE;
                  end
               end
            end
         end
         S_STORE: begin
            // Writes never push; reads wait here with SCLK parked low while RX is full.
            if (op_q || !rx_full) begin
               rx_wr     = !op_q;
               state_nxt = (bits_left != 16'd0) ? S_LOAD : S_DONE;
            end
         end
         S_DONE: begin
            if (div_end) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bits_left <= 16'd0;
         byte_bits <= '0;
         div_cnt   <= 8'd0;
         op_q      <= 1'b0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         sclk_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  bits_left <= len;
                  op_q      <= op;
                  busy_q    <= 1'b1;
               end
            end
            S_LOAD: begin
               tx_sr     <= tx_empty ? '0 : tx_data;
               rx_sr     <= '0;
               byte_bits <= (bits_left >= DATA_BITS) ? DATA_BW : bits_left[BW-1:0];
               cs_n_q    <= 1'b0;
               div_cnt   <= 8'd0;
            end
            S_SHIFT: begin
               div_cnt <= div_end ? 8'd0 : div_cnt + 8'd1;
               if (rise) begin
                  sclk_q <= 1'b1;
                  rx_sr  <= {rx_sr[DATA-2:0], miso};
               end
               if (fall) begin
                  sclk_q    <= 1'b0;
                  tx_sr     <= {tx_sr[DATA-2:0], 1'b0};
                  bits_left <= bits_left - 16'd1;
                  byte_bits <= byte_bits - ONE_BW;
               end
            end
            S_STORE: begin
               div_cnt <= 8'd0;
            end
            S_DONE: begin
               div_cnt <= div_end ? 8'd0 : div_cnt + 8'd1;
               if (div_end) begin
                  cs_n_q <= 1'b1;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               div_cnt <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_core.sv
// tb/tb_spi_master_core.sv - Self-checking bench for spi_master_core
// FIFO and SPI-slave models plus a bitstream-level reference model.
module tb_spi_master_core;

   localparam int DATA = 8;
   localparam int DIV  = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] len;
   logic        op;
   logic        work;
   logic        busy;
   logic [7:0]  tx_data = 8'h00;
   logic        tx_rd;
   logic        tx_empty = 1'b1;
   logic [7:0]  rx_data;
   logic        rx_wr;
   logic        rx_full;
   logic        sclk;
   logic        mosi;
   logic        miso = 1'b0;
   logic        cs_n;

   int errors = 0;
   int checks = 0;

   logic [7:0] tx_src [0:15];
   int         tx_cnt;
   logic [7:0] miso_bytes [0:15];
   int         clr_gen = 0;

   int         clr_seen = 0;
   int         tx_ptr = 0;
   bit         pop_pending = 0;
   int         rise_cnt = 0;
   int         txrd_cnt = 0;
   int         rxwr_cnt = 0;
   int         busy_cyc = 0;
   int         strobe_viol = 0;
   int         cs_viol = 0;
   logic       sclk_prev = 1'b0;
   logic       txrd_prev = 1'b0;
   logic       rxwr_prev = 1'b0;
   logic [7:0] rx_got [$];
   logic       mosi_got [$];

   int         exp_txrd;
   int         exp_rxwr;
   int         exp_busy;
   logic [7:0] exp_rx [$];
   logic       exp_mosi [$];

   spi_master_core #(.DATA(DATA), .DIV(DIV)) dut (
      .clk      (clk),
      .rst      (rst),
      .len      (len),
      .op       (op),
      .work     (work),
      .busy     (busy),
      .tx_data  (tx_data),
      .tx_rd    (tx_rd),
      .tx_empty (tx_empty),
      .rx_data  (rx_data),
      .rx_wr    (rx_wr),
      .rx_full  (rx_full),
      .sclk     (sclk),
      .mosi     (mosi),
      .miso     (miso),
      .cs_n     (cs_n)
   );

   always #5 clk = ~clk;

   function automatic logic miso_bit(input int j);
      logic [7:0] b;
      b = miso_bytes[(j / 8) % 16];
      return b[7 - (j % 8)];
   endfunction

   // FIFO models, SPI slave and activity monitor, all sampled on the falling clock edge.
   always @(negedge clk) begin
      if (clr_gen != clr_seen) begin
         clr_seen    = clr_gen;
         tx_ptr      = 0;
         pop_pending = 0;
         rise_cnt    = 0;
         txrd_cnt    = 0;
         rxwr_cnt    = 0;
         busy_cyc    = 0;
         strobe_viol = 0;
         cs_viol     = 0;
         rx_got.delete();
         mosi_got.delete();
         miso        = miso_bit(0);
      end
      if (pop_pending) begin
         tx_ptr++;
         pop_pending = 0;
      end
      if (tx_rd === 1'b1) begin
         txrd_cnt++;
         pop_pending = 1;
      end
      tx_empty = (tx_ptr >= tx_cnt);
      tx_data  = tx_empty ? 8'h00 : tx_src[tx_ptr % 16];
      if (rx_wr === 1'b1) begin
         rxwr_cnt++;
         rx_got.push_back(rx_data);
      end
      if (busy === 1'b1) busy_cyc++;
      if ((tx_rd && txrd_prev) || (rx_wr && rxwr_prev)) strobe_viol++;
      if (sclk && cs_n) cs_viol++;
      if (sclk && !sclk_prev) begin
         mosi_got.push_back(mosi);
         rise_cnt++;
         miso = miso_bit(rise_cnt);
      end
      sclk_prev = sclk;
      txrd_prev = tx_rd;
      rxwr_prev = rx_wr;
   end

   // Reference: bitstream, byte pushes and busy length derived from len/op and the FIFO contents.
   task automatic model_txn(input int l, input bit o);
      int nb;
      nb = (l + DATA - 1) / DATA;
      exp_mosi.delete();
      exp_rx.delete();
      for (int j = 0; j < l; j++) begin
         logic [7:0] src;
         src = ((j / 8) < tx_cnt) ? tx_src[j / 8] : 8'h00;
         exp_mosi.push_back(src[7 - (j % 8)]);
      end
      for (int b = 0; b < nb; b++) begin
         int bits;
         bits = ((l - 8 * b) >= 8) ? 8 : (l - 8 * b);
         if (!o) exp_rx.push_back(miso_bytes[b] >> (8 - bits));
      end
      exp_txrd = (nb < tx_cnt) ? nb : tx_cnt;
      exp_rxwr = o ? 0 : nb;
      exp_busy = l * 2 * DIV + 2 * nb + DIV;
   endtask

   function automatic int rx_mism();
      int m;
      m = (rx_got.size() == exp_rx.size()) ? 0 : 1;
      for (int i = 0; i < rx_got.size() && i < exp_rx.size(); i++)
         if (rx_got[i] !== exp_rx[i]) m++;
      return m;
   endfunction

   function automatic int mosi_mism();
      int m;
      m = (mosi_got.size() == exp_mosi.size()) ? 0 : 1;
      for (int i = 0; i < mosi_got.size() && i < exp_mosi.size(); i++)
         if (mosi_got[i] !== exp_mosi[i]) m++;
      return m;
   endfunction

   task automatic clr_mon();
      clr_gen++;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic start_txn(input int l, input bit o);
      clr_mon();
      len  = 16'(l);
      op   = o;
      work = 1'b1;
      @(negedge clk);
      work = 1'b0;
   endtask

   task automatic wait_idle(output bit to);
      int n;
      n = 0;
      while (busy === 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      to = (n >= 5000);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, tx_rd, rx_wr, rx_data, sclk, mosi, cs_n} !== {3'b000, 8'h00, 3'b001}) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected %b",
                  {busy, tx_rd, rx_wr, rx_data, sclk, mosi, cs_n}, {3'b000, 8'h00, 3'b001});
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_write();
      bit to;
      tx_cnt = 5;
      tx_src[0] = 8'h00; tx_src[1] = 8'h19; tx_src[2] = 8'h04; tx_src[3] = 8'h0f; tx_src[4] = 8'ha0;
      for (int i = 0; i < 16; i++) miso_bytes[i] = 8'($urandom);
      model_txn(40, 1'b1);
      start_txn(40, 1'b1);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_rise: got %b expected 1", busy); end
      wait_idle(to);
      checks++;
      if (to) begin errors++; $display("FAIL write_timeout: got busy stuck expected idle"); end
      checks++;
      if (mosi_mism() != 0) begin errors++; $display("FAIL write_mosi: got %0d bit errors expected 0", mosi_mism()); end
      checks++;
      if (rise_cnt != 40) begin errors++; $display("FAIL write_rises: got %0d expected 40", rise_cnt); end
      checks++;
      if (txrd_cnt != 5 || rxwr_cnt != 0) begin
         errors++; $display("FAIL write_strobes: got tx_rd=%0d rx_wr=%0d expected 5 and 0", txrd_cnt, rxwr_cnt);
      end
      checks++;
      if (busy_cyc != 334) begin errors++; $display("FAIL write_busy_len: got %0d expected 334", busy_cyc); end
      checks++;
      if (strobe_viol != 0 || cs_viol != 0 || cs_n !== 1'b1) begin
         errors++; $display("FAIL write_protocol: got strobe=%0d cs=%0d cs_n=%b expected 0 0 1", strobe_viol, cs_viol, cs_n);
      end
   endtask

   task automatic test_read_underrun();
      bit to;
      int zero_err;
      tx_cnt = 3;
      tx_src[0] = 8'h00; tx_src[1] = 8'h19; tx_src[2] = 8'h00;
      for (int i = 0; i < 16; i++) miso_bytes[i] = 8'($urandom);
      miso_bytes[3] = 8'ha5;
      miso_bytes[4] = 8'h3c;
      model_txn(40, 1'b0);
      start_txn(40, 1'b0);
      wait_idle(to);
      checks++;
      if (to) begin errors++; $display("FAIL read_timeout: got busy stuck expected idle"); end
      checks++;
      if (txrd_cnt != 3) begin errors++; $display("FAIL read_txrd: got %0d expected 3", txrd_cnt); end
      checks++;
      if (rxwr_cnt != 5) begin errors++; $display("FAIL read_rxwr: got %0d expected 5", rxwr_cnt); end
      checks++;
      if (rx_got.size() != 5 || rx_got[3] !== 8'ha5 || rx_got[4] !== 8'h3c) begin
         errors++; $display("FAIL read_last_bytes: got %0d bytes expected a5,3c at 4 and 5", rx_got.size());
      end
      zero_err = 0;
      for (int j = 24; j < 40 && j < mosi_got.size(); j++) if (mosi_got[j] !== 1'b0) zero_err++;
      checks++;
      if (zero_err != 0 || mosi_got.size() != 40) begin
         errors++; $display("FAIL read_underrun_mosi: got %0d nonzero bits expected 0", zero_err);
      end
      checks++;
      if (rx_mism() != 0 || mosi_mism() != 0) begin
         errors++; $display("FAIL read_data: got %0d/%0d mismatches expected 0", rx_mism(), mosi_mism());
      end
      checks++;
      if (busy_cyc != exp_busy) begin errors++; $display("FAIL read_busy_len: got %0d expected %0d", busy_cyc, exp_busy); end
   endtask

   task automatic test_rx_stall();
      bit to;
      bit bad;
      int falls;
      int n;
      logic prev;
      tx_cnt = 3;
      for (int i = 0; i < 3; i++) tx_src[i] = 8'($urandom);
      for (int i = 0; i < 16; i++) miso_bytes[i] = 8'($urandom);
      model_txn(24, 1'b0);
      rx_full = 1'b1;
      start_txn(24, 1'b0);
      falls = 0;
      n = 0;
      prev = sclk;
      while (falls < 8 && n < 2000) begin
         @(negedge clk);
         n++;
         if (!sclk && prev) falls++;
         prev = sclk;
      end
      bad = (sclk !== 1'b0) || (cs_n !== 1'b0) || (rx_wr !== 1'b0);
      for (int i = 1; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (sclk !== 1'b0 || cs_n !== 1'b0 || rx_wr !== 1'b0) bad = 1'b1;
      end
      @(posedge clk);
      #1;
      rx_full = 1'b0;
      wait_idle(to);
      checks++;
      if (to || n >= 2000) begin errors++; $display("FAIL stall_timeout: got busy stuck expected idle"); end
      checks++;
      if (bad) begin errors++; $display("FAIL stall_hold: got activity during stall expected sclk=0 cs_n=0 no push"); end
      checks++;
      if (busy_cyc != exp_busy + 20) begin
         errors++; $display("FAIL stall_busy_len: got %0d expected %0d", busy_cyc, exp_busy + 20);
      end
      checks++;
      if (rx_mism() != 0) begin errors++; $display("FAIL stall_data: got %0d mismatches expected 0", rx_mism()); end
   endtask

   task automatic test_partial();
      bit to;
      tx_cnt = 2;
      tx_src[0] = 8'($urandom);
      tx_src[1] = 8'($urandom);
      for (int i = 0; i < 16; i++) miso_bytes[i] = 8'hff;
      model_txn(12, 1'b0);
      start_txn(12, 1'b0);
      wait_idle(to);
      checks++;
      if (to) begin errors++; $display("FAIL partial_timeout: got busy stuck expected idle"); end
      checks++;
      if (rise_cnt != 12) begin errors++; $display("FAIL partial_rises: got %0d expected 12", rise_cnt); end
      checks++;
      if (rx_got.size() != 2 || rx_got[0] !== 8'hff || rx_got[1] !== 8'h0f) begin
         errors++; $display("FAIL partial_rx: got %0d bytes expected ff,0f", rx_got.size());
      end
      checks++;
      if (txrd_cnt != 2) begin errors++; $display("FAIL partial_txrd: got %0d expected 2", txrd_cnt); end
      checks++;
      if (mosi_mism() != 0 || busy_cyc != exp_busy) begin
         errors++; $display("FAIL partial_stream: got %0d bit errors busy %0d expected 0 and %0d",
                            mosi_mism(), busy_cyc, exp_busy);
      end
   endtask

   task automatic test_ignored_work();
      bit to;
      int snap;
      tx_cnt = 2;
      tx_src[0] = 8'h5a;
      tx_src[1] = 8'hc3;
      start_txn(0, 1'b0);
      repeat (10) @(negedge clk);
      checks++;
      if (busy_cyc != 0 || txrd_cnt != 0 || cs_n !== 1'b1) begin
         errors++; $display("FAIL len0_ignored: got busy_cyc=%0d tx_rd=%0d cs_n=%b expected 0 0 1", busy_cyc, txrd_cnt, cs_n);
      end
      model_txn(16, 1'b1);
      start_txn(16, 1'b1);
      repeat (40) @(negedge clk);
      len  = 16'd8;
      op   = 1'b0;
      work = 1'b1;
      @(negedge clk);
      work = 1'b0;
      wait_idle(to);
      checks++;
      if (to) begin errors++; $display("FAIL midwork_timeout: got busy stuck expected idle"); end
      checks++;
      if (rise_cnt != 16 || rxwr_cnt != 0 || mosi_mism() != 0) begin
         errors++; $display("FAIL midwork_txn: got rises=%0d rx_wr=%0d expected 16 and 0", rise_cnt, rxwr_cnt);
      end
      snap = busy_cyc;
      repeat (10) @(negedge clk);
      checks++;
      if (busy_cyc != exp_busy || busy_cyc != snap || busy !== 1'b0) begin
         errors++; $display("FAIL midwork_restart: got busy_cyc=%0d expected %0d with no restart", busy_cyc, exp_busy);
      end
   endtask

   task automatic test_reset_mid();
      bit to;
      bit bad;
      int r;
      int n;
      logic prev;
      tx_cnt = 3;
      for (int i = 0; i < 3; i++) tx_src[i] = 8'($urandom);
      for (int i = 0; i < 16; i++) miso_bytes[i] = 8'($urandom);
      start_txn(24, 1'b0);
      r = 0;
      n = 0;
      prev = sclk;
      while (r < 11 && n < 2000) begin
         @(negedge clk);
         n++;
         if (sclk && !prev) r++;
         prev = sclk;
      end
      rst = 1'b0;
      #1;
      checks++;
      if (n >= 2000 || {busy, tx_rd, rx_wr, rx_data, sclk, mosi, cs_n} !== {3'b000, 8'h00, 3'b001}) begin
         errors++; $display("FAIL rst_mid_outputs: got %b expected %b",
                            {busy, tx_rd, rx_wr, rx_data, sclk, mosi, cs_n}, {3'b000, 8'h00, 3'b001});
      end
      bad = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (busy !== 1'b0 || cs_n !== 1'b1 || sclk !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad || txrd_cnt != 2 || rxwr_cnt != 1) begin
         errors++; $display("FAIL rst_mid_fifo: got tx_rd=%0d rx_wr=%0d expected 2 and 1 with outputs held", txrd_cnt, rxwr_cnt);
      end
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) tx_src[i] = 8'($urandom);
      model_txn(20, 1'b0);
      start_txn(20, 1'b0);
      wait_idle(to);
      checks++;
      if (to || rx_mism() != 0 || mosi_mism() != 0 || txrd_cnt != exp_txrd || busy_cyc != exp_busy) begin
         errors++; $display("FAIL rst_mid_recover: got rx_err=%0d mosi_err=%0d busy=%0d expected 0 0 %0d",
                            rx_mism(), mosi_mism(), busy_cyc, exp_busy);
      end
   endtask

   task automatic test_random();
      bit to;
      int l;
      bit o;
      int nb;
      for (int it = 0; it < 6; it++) begin
         l  = $urandom_range(1, 48);
         o  = 1'($urandom_range(0, 1));
         nb = (l + 7) / 8;
         tx_cnt = $urandom_range(0, nb);
         for (int i = 0; i < 16; i++) begin
            tx_src[i]     = 8'($urandom);
            miso_bytes[i] = 8'($urandom);
         end
         model_txn(l, o);
         start_txn(l, o);
         wait_idle(to);
         checks++;
         if (to || rise_cnt != l) begin
            errors++; $display("FAIL rand%0d_rises: got %0d expected %0d", it, rise_cnt, l);
         end
         checks++;
         if (mosi_mism() != 0) begin errors++; $display("FAIL rand%0d_mosi: got %0d bit errors expected 0", it, mosi_mism()); end
         checks++;
         if (rx_mism() != 0 || rxwr_cnt != exp_rxwr) begin
            errors++; $display("FAIL rand%0d_rx: got %0d pushes %0d errors expected %0d pushes", it, rxwr_cnt, rx_mism(), exp_rxwr);
         end
         checks++;
         if (txrd_cnt != exp_txrd) begin errors++; $display("FAIL rand%0d_txrd: got %0d expected %0d", it, txrd_cnt, exp_txrd); end
         checks++;
         if (busy_cyc != exp_busy) begin errors++; $display("FAIL rand%0d_busy: got %0d expected %0d", it, busy_cyc, exp_busy); end
         checks++;
         if (strobe_viol != 0 || cs_viol != 0) begin
            errors++; $display("FAIL rand%0d_protocol: got strobe=%0d cs=%0d expected 0 0", it, strobe_viol, cs_viol);
         end
      end
   endtask

   initial begin
      rst     = 1'b1;
      work    = 1'b0;
      len     = 16'd0;
      op      = 1'b0;
      rx_full = 1'b0;
      tx_cnt  = 0;
      for (int i = 0; i < 16; i++) begin
         tx_src[i]     = 8'h00;
         miso_bytes[i] = 8'h00;
      end
      #3 rst = 1'b0;
      test_reset();
      test_write();
      test_read_underrun();
      test_rx_stall();
      test_partial();
      test_ignored_work();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
